cache_mem_line_xfer: RTL and testbench

- Memory-side line transfer engine for the 4-way set-associative cache.
- Takes one line request per transaction from the miss/evict logic:
  - refill: converts it into a word-serial read burst on the main-memory bus.
  - write-back: converts it into a word-serial write burst.
- Assembles the returned words into a full line and presents it, with a one-cycle valid, to the mem-data pipeline register feeding the cache data array.
- Exactly one transaction is in flight at a time.

---
 rtl/cache_mem_line_xfer.sv | 123 ++++++++++++
 tb/tb_cache_mem_line_xfer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_line_xfer.sv
// Memory-side line transfer engine: one refill or write-back line per
// transaction, serialised into BUS_W beats on the main-memory bus.
module cache_mem_line_xfer #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int BUS_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_rdata,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_we,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [BUS_W-1:0]  mem_wdata,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [BUS_W-1:0]  mem_rdata
);

    localparam int BEATS = LINE_W / BUS_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0]     LAST     = CW'(BEATS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_e;

    state_e                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [BEATS-1:0][BUS_W-1:0]  buf_q, buf_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic                         rw_q, rw_d;
    logic                         ready_q, ready_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            ready_q <= ready_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_rdata = buf_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        buf_d         = buf_q;
        addr_d        = addr_q;
        rw_d          = rw_q;
        ready_d       = 1'b0;
        resp_valid    = 1'b0;
        mem_cmd_valid = 1'b0;
        mem_cmd_we    = 1'b0;
        mem_cmd_addr  = '0;
        mem_wvalid    = 1'b0;
        mem_wdata     = '0;
        mem_rready    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // First idle cycle after reset raises ready; a handshake drops it
                ready_d = !(req_valid && ready_q);
                if (req_valid && ready_q) begin
                    addr_d  = req_addr & ~OFF_MASK;
                    rw_d    = req_rw;
                    buf_d   = req_wdata;
                    state_d = CMD;
                end
            end
            CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_we    = rw_q;
                mem_cmd_addr  = addr_q;
                if (mem_cmd_ready) begin
                    cnt_d   = '0;
                    state_d = rw_q ? WDATA : RDATA;
                end
            end
            WDATA: begin
                mem_wvalid = 1'b1;
                mem_wdata  = buf_q[cnt_q];
                if (mem_wready) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            RDATA: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    buf_d[cnt_q] = mem_rdata;
                    cnt_d        = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                ready_d    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_line_xfer.sv
// Directed bench for cache_mem_line_xfer: refill, write-back, backpressure,
// spurious read beats and mid-transaction reset.
module tb_cache_mem_line_xfer;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_rw;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         req_ready, resp_valid;
    logic [127:0] resp_rdata;
    logic         mem_cmd_valid, mem_cmd_ready, mem_cmd_we;
    logic [31:0]  mem_cmd_addr;
    logic         mem_wvalid, mem_wready;
    logic [31:0]  mem_wdata;
    logic         mem_rvalid, mem_rready;
    logic [31:0]  mem_rdata;

    cache_mem_line_xfer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [31:0]  words[4];
    logic [127:0] rsp_line, wr_line;
    logic [31:0]  cmd_addr_seen;
    logic         cmd_we_seen, ready_after;
    int lat, nresp, nwr, nrd;
    int viol_ready, viol_early, viol_cmd, viol_wstab;

    task automatic txn(input logic rw, input logic [31:0] addr,
                       input logic [127:0] wd, input int cmd_stall,
                       input bit wtog, input bit spur, input int abort_at);
        int   cmdcyc = 0;
        bit   cmd_done = 0, prev_stall = 0, wph = 1;
        logic [31:0] prev_wd = '0;
        lat = -1; nresp = 0; nwr = 0; nrd = 0;
        viol_ready = 0; viol_early = 0; viol_cmd = 0; viol_wstab = 0;
        rsp_line = '0; wr_line = '0; ready_after = 1'b0;
        cmd_addr_seen = '0; cmd_we_seen = 1'b0;
        @(negedge clk);
        check("pre_ready", 128'(req_ready), 128'(1));
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
        mem_rvalid = spur; mem_rdata = spur ? 32'hBAD0_BAD0 : 32'h0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            req_valid = 1'b0; req_addr = '0; req_wdata = '0;
            if (abort_at > 0 && nrd == abort_at) begin
                reset = 1'b0;
                mem_rvalid = 1'b0;
                #1;
                break;
            end
            if (resp_valid) begin
                nresp++;
                rsp_line = resp_rdata;
                if (lat < 0) lat = n;
            end
            if (lat >= 0 && n == lat + 1) begin
                ready_after = req_ready;
                break;
            end
            if (req_ready) viol_ready++;
            if (!cmd_done && (mem_wvalid || mem_rready)) viol_early++;
            if (mem_cmd_valid) begin
                if (cmdcyc == 0) begin
                    cmd_addr_seen = mem_cmd_addr;
                    cmd_we_seen   = mem_cmd_we;
                end else if (mem_cmd_addr !== cmd_addr_seen ||
                             mem_cmd_we !== cmd_we_seen) begin
                    viol_cmd++;
                end
                cmdcyc++;
                mem_cmd_ready = (cmdcyc > cmd_stall);
                if (mem_cmd_ready) cmd_done = 1;
            end else begin
                mem_cmd_ready = 1'b0;
            end
            if (mem_wvalid) begin
                if (prev_stall && mem_wdata !== prev_wd) viol_wstab++;
                mem_wready = wtog ? wph : 1'b1;
                wph = ~wph;
                if (mem_wready) begin
                    if (nwr < 4) wr_line[nwr*32 +: 32] = mem_wdata;
                    nwr++;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev_wd = mem_wdata;
                end
            end else begin
                mem_wready = 1'b0;
            end
            if (mem_rready) begin
                mem_rvalid = 1'b1;
                mem_rdata  = words[nrd % 4];
                nrd++;
            end else begin
                mem_rvalid = spur;
                mem_rdata  = spur ? 32'hBAD0_BAD0 : 32'h0;
            end
        end
        mem_cmd_ready = 1'b0; mem_wready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_seen;
        reset = 1'b0;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
        mem_cmd_ready = 1'b0; mem_wready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;

        // 1: reset state and release
        repeat (3) @(negedge clk);
        check("rst_ctrl", 128'({req_ready, resp_valid, mem_cmd_valid,
              mem_cmd_we, mem_wvalid, mem_rready}), 128'(0));
        check("rst_data", resp_rdata, 128'(0));
        check("rst_bus", 128'({mem_cmd_addr, mem_wdata}), 128'(0));
        reset = 1'b1;
        @(negedge clk);
        check("rel_ready", 128'(req_ready), 128'(1));
        check("rel_valids", 128'({mem_cmd_valid, mem_wvalid, mem_rready}),
              128'(0));

        // 2: refill, no stalls
        words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        txn(1'b0, 32'h0000_1234, '0, 0, 0, 0, 0);
        check("rf_addr", 128'(cmd_addr_seen), 128'(32'h0000_1230));
        check("rf_we", 128'(cmd_we_seen), 128'(0));
        check("rf_line", rsp_line,
              128'h44444444_33333333_22222222_11111111);
        check("rf_lat", 128'(lat), 128'(6));
        check("rf_nresp", 128'(nresp), 128'(1));
        check("rf_reads", 128'(nrd), 128'(4));
        check("rf_ready_after", 128'(ready_after), 128'(1));
        check("rf_busy", 128'(viol_ready), 128'(0));

        // 3: write-back with alternating wready
        txn(1'b1, 32'h8000_004C,
            128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, 1, 0, 0);
        check("wb_addr", 128'(cmd_addr_seen), 128'(32'h8000_0040));
        check("wb_we", 128'(cmd_we_seen), 128'(1));
        check("wb_beats", wr_line,
              128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        check("wb_nbeats", 128'(nwr), 128'(4));
        check("wb_stable", 128'(viol_wstab), 128'(0));
        check("wb_nresp", 128'(nresp), 128'(1));
        check("wb_echo", rsp_line,
              128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        check("wb_lat", 128'(lat), 128'(9));

        // 4: command backpressure for 5 cycles
        words = '{32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 32'h0D0D_0D0D};
        txn(1'b0, 32'h0000_FF08, '0, 5, 0, 0, 0);
        check("bp_addr", 128'(cmd_addr_seen), 128'(32'h0000_FF00));
        check("bp_cmd_stable", 128'(viol_cmd), 128'(0));
        check("bp_no_early", 128'(viol_early), 128'(0));
        check("bp_lat", 128'(lat), 128'(11));
        check("bp_line", rsp_line,
              128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);

        // 5: spurious rvalid outside RDATA
        words = '{32'h5555_0001, 32'h5555_0002, 32'h5555_0003, 32'h5555_0004};
        txn(1'b0, 32'h0000_ABCF, '0, 0, 0, 1, 0);
        check("sp_addr", 128'(cmd_addr_seen), 128'(32'h0000_ABC0));
        check("sp_line", rsp_line,
              128'h55550004_55550003_55550002_55550001);
        check("sp_busy", 128'(viol_ready), 128'(0));
        check("sp_lat", 128'(lat), 128'(6));

        // 6: reset after two read beats, then a fresh refill
        words = '{32'hA5A5_0000, 32'hA5A5_1111, 32'hA5A5_2222, 32'hA5A5_3333};
        txn(1'b0, 32'h0000_2000, '0, 0, 0, 0, 2);
        check("ab_ctrl", 128'({req_ready, resp_valid, mem_cmd_valid,
              mem_wvalid, mem_rready}), 128'(0));
        check("ab_data", resp_rdata, 128'(0));
        rv_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || req_ready) rv_seen++;
        end
        check("ab_quiet", 128'(rv_seen), 128'(0));
        reset = 1'b1;
        @(negedge clk);
        check("ab_rel_ready", 128'(req_ready), 128'(1));
        check("ab_rel_resp", 128'(resp_valid), 128'(0));
        words = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
        txn(1'b0, 32'h0000_3010, '0, 0, 0, 0, 0);
        check("ab2_addr", 128'(cmd_addr_seen), 128'(32'h0000_3010));
        check("ab2_line", rsp_line,
              128'h0D0E0F10_090A0B0C_05060708_01020304);
        check("ab2_nresp", 128'(nresp), 128'(1));
        check("ab2_lat", 128'(lat), 128'(6));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
